// File: rtl/pt2272_decoder.sv
// PT2272-style receive decoder: measures pulse widths on the synchronized
// serial line, rebuilds tri-state code words, checks them against the
// configured address and asserts vt after two identical valid words.
module pt2272_decoder #(
  parameter int ALPHA     = 4,
  parameter int ADDR_BITS = 8,
  parameter int DATA_BITS = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   din,
  input  logic [2*ADDR_BITS-1:0] addr_cfg,
  output logic [DATA_BITS-1:0]   data_out,
  output logic                   vt,
  output logic                   word_err
);

  localparam int NBITS   = ADDR_BITS + DATA_BITS;
  localparam int NPAIRS  = 2 * NBITS;
  localparam int CNT_MAX = 64 * ALPHA;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int PAIR_W  = $clog2(NPAIRS + 1);
  localparam int TMO     = 1024 * ALPHA;
  localparam int TMR_W   = $clog2(TMO);

  typedef enum logic [2:0] {WAIT_SYNC, ARMED, HIGH, LOW, CHECK} state_t;
  typedef enum logic [1:0] {CLS_S, CLS_L, CLS_ERR} cls_t;

  // Width classes shared by high and low pulses; SYNC is detected separately.
  function automatic cls_t classify(input logic [CNT_W-1:0] w);
    if (w >= CNT_W'(2 * ALPHA) && w < CNT_W'(6 * ALPHA))
      return CLS_S;
    else if (w >= CNT_W'(8 * ALPHA) && w < CNT_W'(16 * ALPHA))
      return CLS_L;
    else
      return CLS_ERR;
  endfunction

  logic               din_p0, din_p1, din_p2;
  logic [CNT_W-1:0]   cnt;
  state_t             state;
  logic [PAIR_W-1:0]  pair_cnt;
  cls_t               hi_cls;
  logic               first_pair;
  logic [2*NBITS-1:0] word;
  logic [2*NBITS-1:0] prev_word;
  logic               rep_flag;
  logic [TMR_W-1:0]   tmr;

  logic               rise, fall, low_sync;
  cls_t               cls_now;
  logic               pair_ok, pair_l, trit_ok;
  logic [1:0]         trit;
  logic               addr_ok, data_ok;
  logic [DATA_BITS-1:0] data_bits;

  // Two-flop synchronizer plus one delay stage for edge detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      din_p0 <= 1'b0;
      din_p1 <= 1'b0;
      din_p2 <= 1'b0;
    end else begin
      din_p0 <= din;
      din_p1 <= din_p0;
      din_p2 <= din_p1;
    end
  end

  assign rise     = din_p1 & ~din_p2;
  assign fall     = ~din_p1 & din_p2;
  assign low_sync = ~din_p1 & ~din_p2 & (cnt == CNT_W'(CNT_MAX));

  // Level-width counter: restarts on every edge, saturates at the sync length.
  always_ff @(posedge clk) begin
    if (rst)
      cnt <= '0;
    else if (rise || fall)
      cnt <= CNT_W'(1);
    else if (cnt != CNT_W'(CNT_MAX))
      cnt <= cnt + CNT_W'(1);
  end

  // Pair and trit decode from the stored high class and the low just ended.
  always_comb begin
    cls_now = classify(cnt);
    pair_ok = (hi_cls == CLS_S && cls_now == CLS_L) ||
              (hi_cls == CLS_L && cls_now == CLS_S);
    pair_l  = (hi_cls == CLS_L);
    trit_ok = !(first_pair && !pair_l);
    trit    = {~first_pair & pair_l, first_pair & pair_l};
  end

  // Word check: address trits must match exactly, data trits must not be F.
  always_comb begin
    addr_ok   = 1'b1;
    data_ok   = 1'b1;
    data_bits = '0;
    for (int i = 0; i < ADDR_BITS; i++)
      if (addr_cfg[2*i +: 2] == 2'b11 || word[2*i +: 2] != addr_cfg[2*i +: 2])
        addr_ok = 1'b0;
    for (int i = 0; i < DATA_BITS; i++) begin
      if (word[2*(ADDR_BITS+i)+1])
        data_ok = 1'b0;
      data_bits[i] = word[2*(ADDR_BITS+i)];
    end
  end

  // Frame FSM with repeat detection, vt timeout and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= WAIT_SYNC;
      pair_cnt   <= '0;
      hi_cls     <= CLS_S;
      first_pair <= 1'b0;
      rep_flag   <= 1'b0;
      tmr        <= '0;
      data_out   <= '0;
      vt         <= 1'b0;
      word_err   <= 1'b0;
    end else begin
      word_err <= 1'b0;
      // The repeat branch in CHECK is written later so it overrides expiry.
      if (vt) begin
        if (tmr == TMR_W'(TMO - 1))
          vt <= 1'b0;
        else
          tmr <= tmr + TMR_W'(1);
      end
      case (state)
        WAIT_SYNC: begin
          if (low_sync)
            state <= ARMED;
        end
        ARMED: begin
          if (rise) begin
            pair_cnt <= '0;
            state    <= HIGH;
          end
        end
        HIGH: begin
          if (fall) begin
            hi_cls <= cls_now;
            if (cls_now == CLS_ERR ||
                (pair_cnt == PAIR_W'(NPAIRS) && cls_now != CLS_S)) begin
              word_err <= 1'b1;
              rep_flag <= 1'b0;
              state    <= WAIT_SYNC;
            end else begin
              state <= LOW;
            end
          end
        end
        LOW: begin
          if (low_sync) begin
            if (pair_cnt == PAIR_W'(NPAIRS)) begin
              state <= CHECK;
            end else begin
              word_err <= 1'b1;
              rep_flag <= 1'b0;
              state    <= ARMED;
            end
          end else if (rise) begin
            if (pair_cnt == PAIR_W'(NPAIRS) || !pair_ok ||
                (pair_cnt[0] && !trit_ok)) begin
              word_err <= 1'b1;
              rep_flag <= 1'b0;
              state    <= WAIT_SYNC;
            end else begin
              if (!pair_cnt[0])
                first_pair <= pair_l;
              else
                word <= {trit, word[2*NBITS-1:2]};
              pair_cnt <= pair_cnt + PAIR_W'(1);
              state    <= HIGH;
            end
          end
        end
        CHECK: begin
          state <= ARMED;
          if (addr_ok && data_ok) begin
            if (rep_flag && word == prev_word) begin
              data_out <= data_bits;
              vt       <= 1'b1;
              tmr      <= '0;
            end else begin
              prev_word <= word;
              rep_flag  <= 1'b1;
            end
          end else begin
            vt       <= 1'b0;
            rep_flag <= 1'b0;
            word_err <= 1'b1;
          end
        end
        default: state <= WAIT_SYNC;
      endcase
    end
  end

endmodule

// File: tb/tb_pt2272_decoder.sv
// Self-checking bench for pt2272_decoder: table of hand-derived words,
// hand-written corner sequences and random words against a word-level model.
module tb_pt2272_decoder;

  localparam int ALPHA    = 4;
  localparam int SW       = 4 * ALPHA;
  localparam int LW       = 12 * ALPHA;
  localparam int SYNC_LEN = 300;
  localparam logic [15:0] CFG = 16'h4924;  // trits 0,1,F,0,1,F,0,1

  logic        clk = 1'b0;
  logic        rst;
  logic        din;
  logic [15:0] addr_cfg;
  logic [3:0]  data_out;
  logic        vt;
  logic        word_err;

  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;
  int err_cnt = 0;
  int rise_cyc = -1;
  logic vt_q = 1'b0;
  int last_low_start = 0;

  // word-level reference state
  logic        m_vt = 1'b0;
  logic        m_rep = 1'b0;
  logic [3:0]  m_data = 4'h0;
  logic [23:0] m_prev = '0;
  int          m_err = 0;
  int          m_set = 0;

  typedef struct {
    logic [23:0] trits;   // {D3..D0, A7..A0}, 2 bits per trit: 00=0 01=1 10=F
    int          hi0;     // width of the closing sync-pair high
    logic        exp_vt;
    logic [3:0]  exp_data;
    int          exp_err; // word_err pulses caused by this word
  } vec_t;

  pt2272_decoder #(.ALPHA(ALPHA), .ADDR_BITS(8), .DATA_BITS(4)) dut (
    .clk(clk), .rst(rst), .din(din), .addr_cfg(addr_cfg),
    .data_out(data_out), .vt(vt), .word_err(word_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (word_err) err_cnt++;
    if (vt && !vt_q) rise_cyc = cyc;
    vt_q = vt;
  end

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic hold(input logic v, input int n);
    din = v;
    repeat (n) @(negedge clk);
  endtask

  // 's' pair = short high + long low, 'l' pair = long high + short low
  task automatic send_pair(input bit l);
    if (!l) begin hold(1'b1, SW); hold(1'b0, LW); end
    else    begin hold(1'b1, LW); hold(1'b0, SW); end
  endtask

  task automatic send_trit(input logic [1:0] t);
    send_pair(t == 2'b01);
    send_pair(t != 2'b00);
  endtask

  task automatic send_word(input logic [23:0] tw, input int hi0);
    for (int k = 0; k < 12; k++) send_trit(tw[2*k +: 2]);
    hold(1'b1, hi0);
    last_low_start = cyc;
    hold(1'b0, SYNC_LEN);
  endtask

  task automatic model_timeout();
    if (m_vt && (cyc - m_set) >= 1024 * ALPHA) m_vt = 1'b0;
  endtask

  task automatic model_error();
    model_timeout();
    m_err++;
    m_rep = 1'b0;
  endtask

  task automatic model_word(input logic [23:0] tw, input int hi0);
    logic ok;
    logic [3:0] d;
    model_timeout();
    if (hi0 < 2 * ALPHA || hi0 >= 6 * ALPHA) begin
      m_err++;
      m_rep = 1'b0;
      return;
    end
    ok = 1'b1;
    for (int i = 0; i < 8; i++)
      if (CFG[2*i +: 2] == 2'b11 || tw[2*i +: 2] != CFG[2*i +: 2]) ok = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (tw[16 + 2*i +: 2] == 2'b10) ok = 1'b0;
      d[i] = tw[16 + 2*i];
    end
    if (!ok) begin
      m_err++; m_rep = 1'b0; m_vt = 1'b0;
    end else if (m_rep && tw == m_prev) begin
      m_vt = 1'b1; m_data = d; m_set = cyc;
    end else begin
      m_prev = tw; m_rep = 1'b1;
    end
  endtask

  task automatic check_model(input string tag);
    check({tag, "_vt"}, vt, m_vt);
    check({tag, "_data"}, data_out, m_data);
    check({tag, "_errs"}, err_cnt, m_err);
  endtask

  initial begin
    vec_t tbl[14];
    logic [23:0] g;
    logic [23:0] tw;
    logic [23:0] last_tw;
    int bad, e0, set_c, idx, hi0;
    logic [1:0] t;

    g = {8'h11, CFG};                 // data D0..D3 = 1,0,1,0
    tbl[0]  = '{g,                16, 1'b0, 4'h0, 0};
    tbl[1]  = '{g,                16, 1'b1, 4'h5, 0};
    tbl[2]  = '{g,                16, 1'b1, 4'h5, 0};
    tbl[3]  = '{{8'h11, 16'h4925}, 16, 1'b0, 4'h5, 1};  // A0 sent as 1
    tbl[4]  = '{{8'h11, 16'h4925}, 16, 1'b0, 4'h5, 1};
    tbl[5]  = '{{8'h21, CFG},      16, 1'b0, 4'h5, 1};  // D2 sent as F
    tbl[6]  = '{g,                 7, 1'b0, 4'h5, 1};   // sync high 7 < 2a
    tbl[7]  = '{{8'h05, CFG},       8, 1'b0, 4'h5, 0};  // data 1,1,0,0
    tbl[8]  = '{{8'h05, CFG},      23, 1'b1, 4'h3, 0};
    tbl[9]  = '{{8'h54, CFG},      16, 1'b1, 4'h3, 0};  // data 0,1,1,1
    tbl[10] = '{{8'h54, CFG},      16, 1'b1, 4'hE, 0};
    tbl[11] = '{{8'h54, CFG},      24, 1'b1, 4'hE, 1};  // sync high 24 = 6a
    tbl[12] = '{{8'h54, CFG},      16, 1'b1, 4'hE, 0};
    tbl[13] = '{{8'h54, CFG},      16, 1'b1, 4'hE, 0};

    // Reset with din low, then idle
    addr_cfg = CFG;
    rst = 1'b1;
    hold(1'b0, 3);
    rst = 1'b0;
    check("rst_data", data_out, 0);
    check("rst_vt", vt, 0);
    check("rst_err", word_err, 0);
    bad = 0;
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      if (vt || word_err || data_out != 4'h0) bad++;
    end
    check("idle_quiet", bad, 0);

    // Table-driven words
    for (int i = 0; i < 14; i++) begin
      e0 = err_cnt;
      rise_cyc = -1;
      send_word(tbl[i].trits, tbl[i].hi0);
      model_word(tbl[i].trits, tbl[i].hi0);
      check($sformatf("tbl%0d_vt", i), vt, tbl[i].exp_vt);
      check($sformatf("tbl%0d_data", i), data_out, tbl[i].exp_data);
      check($sformatf("tbl%0d_err", i), err_cnt - e0, tbl[i].exp_err);
      if (i == 1) begin
        // 2 sync + 256 count + CHECK + output register: expect 260
        bad = (rise_cyc >= last_low_start + 258 && rise_cyc <= last_low_start + 261) ? 1 : 0;
        if (!bad) $display("FAIL vt_latency: rise at %0d, low start %0d", rise_cyc, last_low_start);
        n_chk++;
        if (bad) n_pass++;
      end
    end

    // Glitch: 1a high inside A3, then sync and two good words
    e0 = err_cnt;
    for (int k = 0; k < 3; k++) send_trit(CFG[2*k +: 2]);
    hold(1'b1, ALPHA);
    hold(1'b0, SYNC_LEN);
    model_error();
    check("glitch_err", err_cnt - e0, 1);
    tw = {8'h50, CFG};                // data 0,0,1,1
    send_word(tw, 16); model_word(tw, 16); check_model("glitch_w1");
    send_word(tw, 16); model_word(tw, 16); check_model("glitch_w2");
    check("glitch_vt", vt, 1);
    check("glitch_data", data_out, 4'hC);

    // Timeout: hold din low after the last completion
    set_c = last_low_start + 260;
    while (cyc < set_c + 4090) @(negedge clk);
    check("tmo_before_vt", vt, 1);
    while (cyc < set_c + 4102) @(negedge clk);
    check("tmo_after_vt", vt, 0);
    check("tmo_data_hold", data_out, 4'hC);

    // Random words against the word-level model
    last_tw = tw;
    for (int n = 0; n < 12; n++) begin
      if ($urandom_range(0, 9) < 4) begin
        tw = last_tw;
      end else begin
        tw[15:0] = CFG;
        if ($urandom_range(0, 4) == 0) begin
          idx = $urandom_range(0, 7);
          t = tw[2*idx +: 2];
          tw[2*idx +: 2] = (t == 2'b10) ? 2'b00 : t + 2'b01;
        end
        for (int i = 0; i < 4; i++) tw[16 + 2*i +: 2] = {1'b0, 1'($urandom_range(0, 1))};
        if ($urandom_range(0, 9) == 0) begin
          idx = $urandom_range(0, 3);
          tw[16 + 2*idx +: 2] = 2'b10;
        end
      end
      hi0 = ($urandom_range(0, 6) == 0) ? int'($urandom_range(6, 26)) : SW;
      send_word(tw, hi0);
      model_word(tw, hi0);
      check_model($sformatf("rnd%0d", n));
      last_tw = tw;
    end

    // Reset mid-word after vt is up
    send_word(g, 16); model_word(g, 16);
    send_word(g, 16); model_word(g, 16);
    check("pre_rst_vt", vt, 1);
    for (int k = 0; k < 5; k++) send_trit(g[2*k +: 2]);
    hold(1'b1, 6);
    rst = 1'b1;
    hold(1'b0, 2);
    rst = 1'b0;
    @(negedge clk);
    m_vt = 1'b0; m_rep = 1'b0; m_data = 4'h0;
    check("midrst_data", data_out, 0);
    check("midrst_vt", vt, 0);
    check("midrst_err", word_err, 0);
    hold(1'b0, SYNC_LEN);
    send_word(g, 16); model_word(g, 16);
    check("post_rst_w1_vt", vt, 0);
    send_word(g, 16); model_word(g, 16);
    check("post_rst_w2_vt", vt, 1);
    check("post_rst_w2_data", data_out, 4'h5);
    check_model("post_rst");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
